wishbone_reg_responder: RTL and testbench

//  Wishbone responder (target) exposing a small 8-bit register bank to an upstream Wishbone controller.

---
 rtl/wishbone_reg_responder_pkg.sv | 30 +++
 rtl/wishbone_reg_responder_irq_flag_bank.sv | 44 ++++
 rtl/wishbone_reg_responder.sv | 203 ++++++++++++++++++++
 tb/tb_wishbone_reg_responder.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/wishbone_reg_responder_pkg.sv
// Shared register map, FSM encodings and decode helper for the Wishbone register responder.
package wishbone_reg_responder_pkg;

  localparam logic [2:0] REG_CTRL      = 3'd0;
  localparam logic [2:0] REG_CMD       = 3'd1;
  localparam logic [2:0] REG_STATUS    = 3'd2;
  localparam logic [2:0] REG_IRQ_FLAGS = 3'd3;
  localparam logic [2:0] REG_IRQ_MASK  = 3'd4;
  localparam logic [2:0] REG_SCRATCH   = 3'd5;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT,
    ST_RESP,
    ST_HOLD
  } state_t;

  typedef enum logic [1:0] {
    RSP_NONE,
    RSP_ACK,
    RSP_ERR,
    RSP_RTY
  } resp_t;

  // Indices 6 and 7 have no register behind them.
  function automatic logic idx_mapped(input logic [2:0] idx);
    return idx <= REG_SCRATCH;
  endfunction

endpackage

// File: rtl/wishbone_reg_responder_irq_flag_bank.sv
// Eight sticky write-one-to-clear interrupt flags with an enable mask and a registered IRQ line.
module irq_flag_bank (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] set,
  input  logic [7:0] clr,
  input  logic       mask_we,
  input  logic [7:0] mask_din,
  output logic [7:0] flags,
  output logic [7:0] mask,
  output logic       irq
);

  logic [7:0] flags_reg;
  logic [7:0] flags_next;
  logic [7:0] mask_reg;
  logic       irq_reg;

  // A set pulse in the same cycle as a clear keeps the flag asserted.
  generate
    for (genvar gi = 0; gi < 8; gi++) begin : g_flag
      assign flags_next[gi] = (flags_reg[gi] & ~clr[gi]) | set[gi];
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      flags_reg <= 8'h00;
      mask_reg  <= 8'h00;
      irq_reg   <= 1'b0;
    end else begin
      flags_reg <= flags_next;
      if (mask_we) begin
        mask_reg <= mask_din;
      end
      irq_reg <= |(flags_reg & mask_reg);
    end
  end

  assign flags = flags_reg;
  assign mask  = mask_reg;
  assign irq   = irq_reg;

endmodule

// File: rtl/wishbone_reg_responder.sv
// Wishbone target exposing an 8-bit register bank (control, command, status, IRQ, scratch)
// with a programmable response delay and ack/err/rty termination.
module wishbone_reg_responder
  import wishbone_reg_responder_pkg::*;
#(
  parameter int dwidth    = 32,
  parameter int awidth    = 32,
  parameter int ACK_DELAY = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [awidth-1:0]     adr,
  input  logic [dwidth-1:0]     din,
  output logic [dwidth-1:0]     dout_out,
  input  logic                  cyc,
  input  logic                  stb,
  input  logic                  we,
  input  logic [dwidth/8-1:0]   sel,
  output logic                  ack_out,
  output logic                  err_out,
  output logic                  rty_out,
  output logic [7:0]            ctrl_out,
  output logic                  cmd_pulse_out,
  output logic [7:0]            cmd_data_out,
  input  logic [7:0]            status_in,
  input  logic                  busy_in,
  input  logic [7:0]            irq_set_in,
  output logic                  irq_out
);

  localparam logic [3:0] DELAY_M1 = 4'(ACK_DELAY - 1);

  state_t            state_reg, state_next;
  logic [3:0]        cnt_reg, cnt_next;
  logic [awidth-1:0] adr_reg;
  logic [7:0]        wdata_reg;
  logic              we_reg;
  logic              sel0_reg;

  logic              ack_reg, err_reg, rty_reg;
  logic              cmd_pulse_reg;
  logic [7:0]        cmd_data_reg;
  logic [7:0]        ctrl_reg;
  logic [7:0]        scratch_reg;
  logic [7:0]        dout_reg;

  logic              req;
  logic              wait_done;
  logic [2:0]        idx;
  logic              dec_err;
  resp_t             resp_next;
  logic              wr_en;
  logic              rd_en;
  logic [7:0]        rdata;
  logic [7:0]        irq_clr;
  logic [7:0]        irq_flags;
  logic [7:0]        irq_mask;
  logic              irq_line;

  assign req       = cyc & stb;
  assign wait_done = (cnt_reg == DELAY_M1);
  assign idx       = adr_reg[2:0];
  assign dec_err   = (adr_reg[awidth-1:3] != '0) || !idx_mapped(idx);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= ST_IDLE;
      cnt_reg   <= 4'd0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    unique case (state_reg)
      ST_IDLE: begin
        if (req) begin
          state_next = ST_WAIT;
          cnt_next   = 4'd0;
        end
      end
      ST_WAIT: begin
        if (!req) begin
          state_next = ST_IDLE;
        end else if (wait_done) begin
          state_next = ST_RESP;
        end else begin
          cnt_next = cnt_reg + 4'd1;
        end
      end
      ST_RESP: state_next = ST_HOLD;
      // Stay here while the controller keeps stb up past the strobe so it cannot re-trigger.
      ST_HOLD: begin
        if (!req) begin
          state_next = ST_IDLE;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_comb begin
    resp_next = RSP_NONE;
    if (state_reg == ST_WAIT && req && wait_done) begin
      if (dec_err) begin
        resp_next = RSP_ERR;
      end else if (we_reg && idx == REG_CMD && busy_in) begin
        resp_next = RSP_RTY;
      end else begin
        resp_next = RSP_ACK;
      end
    end
    wr_en = (resp_next == RSP_ACK) && we_reg && sel0_reg;
    rd_en = (resp_next == RSP_ACK) && !we_reg;
  end

  always_comb begin
    rdata = 8'h00;
    case (idx)
      REG_CTRL:      rdata = ctrl_reg;
      REG_STATUS:    rdata = status_in;
      REG_IRQ_FLAGS: rdata = irq_flags;
      REG_IRQ_MASK:  rdata = irq_mask;
      REG_SCRATCH:   rdata = scratch_reg;
      default:       rdata = 8'h00;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      adr_reg   <= '0;
      wdata_reg <= 8'h00;
      we_reg    <= 1'b0;
      sel0_reg  <= 1'b0;
    end else if (state_reg == ST_IDLE && req) begin
      adr_reg   <= adr;
      wdata_reg <= din[7:0];
      we_reg    <= we;
      sel0_reg  <= sel[0];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ack_reg       <= 1'b0;
      err_reg       <= 1'b0;
      rty_reg       <= 1'b0;
      cmd_pulse_reg <= 1'b0;
      cmd_data_reg  <= 8'h00;
      ctrl_reg      <= 8'h00;
      scratch_reg   <= 8'h00;
      dout_reg      <= 8'h00;
    end else begin
      ack_reg       <= (resp_next == RSP_ACK);
      err_reg       <= (resp_next == RSP_ERR);
      rty_reg       <= (resp_next == RSP_RTY);
      cmd_pulse_reg <= wr_en && (idx == REG_CMD);
      if (wr_en && idx == REG_CTRL) begin
        ctrl_reg <= wdata_reg;
      end
      if (wr_en && idx == REG_CMD) begin
        cmd_data_reg <= wdata_reg;
      end
      if (wr_en && idx == REG_SCRATCH) begin
        scratch_reg <= wdata_reg;
      end
      if (rd_en) begin
        dout_reg <= rdata;
      end
    end
  end

  assign irq_clr = (wr_en && idx == REG_IRQ_FLAGS) ? wdata_reg : 8'h00;

  irq_flag_bank u_irq (
    .clk      (clk),
    .rst      (rst),
    .set      (irq_set_in),
    .clr      (irq_clr),
    .mask_we  (wr_en && idx == REG_IRQ_MASK),
    .mask_din (wdata_reg),
    .flags    (irq_flags),
    .mask     (irq_mask),
    .irq      (irq_line)
  );

  assign dout_out      = {{(dwidth-8){1'b0}}, dout_reg};
  assign ack_out       = ack_reg;
  assign err_out       = err_reg;
  assign rty_out       = rty_reg;
  assign ctrl_out      = ctrl_reg;
  assign cmd_pulse_out = cmd_pulse_reg;
  assign cmd_data_out  = cmd_data_reg;
  assign irq_out       = irq_line;

  // Only the low data byte and sel[0] carry meaning on this bus.
  logic unused_bits;
  assign unused_bits = &{1'b0, din[dwidth-1:8], sel};

endmodule

// File: tb/tb_wishbone_reg_responder.sv
// Directed bench: one instance with ACK_DELAY=1 and one with ACK_DELAY=4 sharing the bus wires.
module tb_wishbone_reg_responder;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] adr = '0;
  logic [31:0] din = '0;
  logic        cyc = 1'b0;
  logic        stb = 1'b0;
  logic        we  = 1'b0;
  logic [3:0]  sel = '0;
  logic [7:0]  status_in  = 8'h00;
  logic        busy_in    = 1'b0;
  logic [7:0]  irq_set_in = 8'h00;
  logic        use4 = 1'b0;

  logic        cyc1, cyc4;
  logic [31:0] dout1, dout4;
  logic        ack1, err1, rty1, pulse1, irq1;
  logic        ack4, err4, rty4, pulse4, irq4;
  logic [7:0]  ctrl1, ctrl4, cmd1, cmd4;

  int checks = 0;
  int errors = 0;

  assign cyc1 = cyc & ~use4;
  assign cyc4 = cyc & use4;

  always #5 clk = ~clk;

  wishbone_reg_responder #(.dwidth(32), .awidth(32), .ACK_DELAY(1)) dut1 (
    .clk(clk), .rst(rst), .adr(adr), .din(din), .dout_out(dout1),
    .cyc(cyc1), .stb(stb), .we(we), .sel(sel),
    .ack_out(ack1), .err_out(err1), .rty_out(rty1),
    .ctrl_out(ctrl1), .cmd_pulse_out(pulse1), .cmd_data_out(cmd1),
    .status_in(status_in), .busy_in(busy_in), .irq_set_in(irq_set_in), .irq_out(irq1)
  );

  wishbone_reg_responder #(.dwidth(32), .awidth(32), .ACK_DELAY(4)) dut4 (
    .clk(clk), .rst(rst), .adr(adr), .din(din), .dout_out(dout4),
    .cyc(cyc4), .stb(stb), .we(we), .sel(sel),
    .ack_out(ack4), .err_out(err4), .rty_out(rty4),
    .ctrl_out(ctrl4), .cmd_pulse_out(pulse4), .cmd_data_out(cmd4),
    .status_in(status_in), .busy_in(busy_in), .irq_set_in(irq_set_in), .irq_out(irq4)
  );

  logic [2:0]  rsp_v;
  logic        pulse_v;
  logic [31:0] dout_v;
  assign rsp_v   = use4 ? {ack4, err4, rty4} : {ack1, err1, rty1};
  assign pulse_v = use4 ? pulse4 : pulse1;
  assign dout_v  = use4 ? dout4 : dout1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One bus cycle; stb is held past the response strobe as the controller does.
  task automatic xfer(input logic w, input logic [31:0] a, input logic [31:0] d, input logic s0,
                      output logic [2:0] rsp, output int lat, output logic [2:0] hold_rsp,
                      output logic p_at, output logic p_after);
    @(posedge clk); #1;
    adr = a; din = d; we = w; sel = {3'b000, s0}; cyc = 1'b1; stb = 1'b1;
    rsp = 3'b000; lat = 0; p_at = 1'b0;
    while (rsp == 3'b000 && lat < 40) begin
      @(negedge clk);
      lat++;
      rsp  = rsp_v;
      p_at = pulse_v;
    end
    @(negedge clk);
    hold_rsp = rsp_v;
    p_after  = pulse_v;
    @(posedge clk); #1;
    cyc = 1'b0; stb = 1'b0; we = 1'b0;
    $display("xfer dut%0d we=%0b adr=%h din=%h sel0=%0b -> ack/err/rty=%b lat=%0d dout=%h",
             use4 ? 4 : 1, w, a, d, s0, rsp, lat, dout_v);
  endtask

  initial begin
    logic [2:0] rsp, hold;
    int         lat;
    logic       p_at, p_after;
    int         cnt;

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset_strobes", {27'd0, ack1, err1, rty1, pulse1, irq1}, 32'd0);
    check("reset_ctrl_cmd", {16'd0, ctrl1, cmd1}, 32'd0);
    check("reset_dout", dout1, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;

    // Write CTRL then read back; ACK_DELAY=1 gives the ack at the 3rd negedge after driving
    xfer(1'b1, 32'h0, 32'h0000_00A5, 1'b1, rsp, lat, hold, p_at, p_after);
    check("ctrl_wr_rsp", {29'd0, rsp}, 32'b100);
    check("ctrl_wr_lat", lat, 3);
    check("ctrl_wr_hold_no_rsp", {29'd0, hold}, 32'd0);
    check("ctrl_out", {24'd0, ctrl1}, 32'hA5);
    xfer(1'b0, 32'h0, 32'h0, 1'b1, rsp, lat, hold, p_at, p_after);
    check("ctrl_rd_rsp", {29'd0, rsp}, 32'b100);
    check("ctrl_rd_dout", dout1, 32'h0000_00A5);

    // sel[0]=0 write is acked but changes nothing
    xfer(1'b1, 32'h0, 32'h0000_0011, 1'b0, rsp, lat, hold, p_at, p_after);
    check("sel0_wr_rsp", {29'd0, rsp}, 32'b100);
    check("sel0_ctrl_kept", {24'd0, ctrl1}, 32'hA5);

    // STATUS read is live; STATUS write acked
    status_in = 8'h5A;
    xfer(1'b0, 32'h2, 32'h0, 1'b1, rsp, lat, hold, p_at, p_after);
    check("status_rd_dout", dout1, 32'h0000_005A);
    xfer(1'b1, 32'h2, 32'h0000_00FF, 1'b1, rsp, lat, hold, p_at, p_after);
    check("status_wr_rsp", {29'd0, rsp}, 32'b100);

    // Decode errors
    xfer(1'b0, 32'h6, 32'h0, 1'b1, rsp, lat, hold, p_at, p_after);
    check("err_idx6_rsp", {29'd0, rsp}, 32'b010);
    check("err_idx6_dout_kept", dout1, 32'h0000_005A);
    xfer(1'b0, 32'h100, 32'h0, 1'b1, rsp, lat, hold, p_at, p_after);
    check("err_hiadr_rsp", {29'd0, rsp}, 32'b010);
    check("err_hiadr_hold", {29'd0, hold}, 32'd0);
    xfer(1'b1, 32'h108, 32'h0000_00FF, 1'b1, rsp, lat, hold, p_at, p_after);
    check("err_hiadr_wr_rsp", {29'd0, rsp}, 32'b010);
    check("err_hiadr_ctrl_kept", {24'd0, ctrl1}, 32'hA5);

    // CMD write: pulse when idle, retry when busy
    busy_in = 1'b0;
    xfer(1'b1, 32'h1, 32'h0000_003C, 1'b1, rsp, lat, hold, p_at, p_after);
    check("cmd_wr_rsp", {29'd0, rsp}, 32'b100);
    check("cmd_pulse_at_ack", {31'd0, p_at}, 32'd1);
    check("cmd_pulse_one_cycle", {31'd0, p_after}, 32'd0);
    check("cmd_data", {24'd0, cmd1}, 32'h3C);
    xfer(1'b0, 32'h1, 32'h0, 1'b1, rsp, lat, hold, p_at, p_after);
    check("cmd_rd_zero", dout1, 32'd0);
    busy_in = 1'b1;
    xfer(1'b1, 32'h1, 32'h0000_0099, 1'b1, rsp, lat, hold, p_at, p_after);
    check("cmd_busy_rsp", {29'd0, rsp}, 32'b001);
    check("cmd_busy_no_pulse", {31'd0, p_at}, 32'd0);
    check("cmd_busy_data_kept", {24'd0, cmd1}, 32'h3C);
    busy_in = 1'b0;

    xfer(1'b1, 32'h5, 32'h0000_00C3, 1'b1, rsp, lat, hold, p_at, p_after);
    xfer(1'b0, 32'h5, 32'h0, 1'b1, rsp, lat, hold, p_at, p_after);
    check("scratch_rd", dout1, 32'h0000_00C3);

    // IRQ: flags sticky, mask gates irq_out, set beats simultaneous clear
    @(posedge clk); #1; irq_set_in = 8'h05;
    @(posedge clk); #1; irq_set_in = 8'h00;
    @(posedge clk); @(negedge clk);
    check("irq_masked_off", {31'd0, irq1}, 32'd0);
    xfer(1'b1, 32'h4, 32'h0000_0004, 1'b1, rsp, lat, hold, p_at, p_after);
    @(negedge clk);
    check("irq_on", {31'd0, irq1}, 32'd1);
    xfer(1'b0, 32'h3, 32'h0, 1'b1, rsp, lat, hold, p_at, p_after);
    check("irq_flags_rd", dout1, 32'h0000_0005);
    irq_set_in = 8'h04;
    xfer(1'b1, 32'h3, 32'h0000_0004, 1'b1, rsp, lat, hold, p_at, p_after);
    irq_set_in = 8'h00;
    xfer(1'b0, 32'h3, 32'h0, 1'b1, rsp, lat, hold, p_at, p_after);
    check("irq_set_wins", dout1, 32'h0000_0005);
    xfer(1'b1, 32'h3, 32'h0000_0005, 1'b1, rsp, lat, hold, p_at, p_after);
    xfer(1'b0, 32'h3, 32'h0, 1'b1, rsp, lat, hold, p_at, p_after);
    check("irq_w1c_cleared", dout1, 32'd0);
    check("irq_off", {31'd0, irq1}, 32'd0);

    // ACK_DELAY=4 instance: ack at the 6th negedge, aborted request has no effect
    use4 = 1'b1;
    xfer(1'b1, 32'h5, 32'h0000_0021, 1'b1, rsp, lat, hold, p_at, p_after);
    check("d4_wr_rsp", {29'd0, rsp}, 32'b100);
    check("d4_wr_lat", lat, 6);
    check("d4_hold_single_ack", {29'd0, hold}, 32'd0);
    @(posedge clk); #1;
    adr = 32'h5; din = 32'h33; we = 1'b1; sel = 4'b0001; cyc = 1'b1; stb = 1'b1;
    repeat (3) @(negedge clk);
    cyc = 1'b0; stb = 1'b0; we = 1'b0;
    cnt = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (ack4 | err4 | rty4) cnt++;
    end
    $display("xfer dut4 aborted write adr=5 din=33 -> strobes=%0d", cnt);
    check("d4_abort_no_rsp", cnt, 0);
    xfer(1'b0, 32'h5, 32'h0, 1'b1, rsp, lat, hold, p_at, p_after);
    check("d4_abort_no_write", dout4, 32'h0000_0021);
    check("d4_rd_lat", lat, 6);

    // Reset during WAIT of a SCRATCH write
    @(posedge clk); #1;
    adr = 32'h5; din = 32'h77; we = 1'b1; sel = 4'b0001; cyc = 1'b1; stb = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0; cyc = 1'b0; stb = 1'b0; we = 1'b0;
    @(negedge clk);
    check("rst_d4_strobes", {27'd0, ack4, err4, rty4, pulse4, irq4}, 32'd0);
    check("rst_d4_dout", dout4, 32'd0);
    check("rst_d1_ctrl_cmd", {16'd0, ctrl1, cmd1}, 32'd0);
    cnt = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (ack4 | err4 | rty4) cnt++;
    end
    $display("xfer dut4 write adr=5 din=77 cut by reset -> strobes=%0d", cnt);
    check("rst_no_rsp", cnt, 0);
    xfer(1'b0, 32'h5, 32'h0, 1'b1, rsp, lat, hold, p_at, p_after);
    check("rst_scratch_rsp", {29'd0, rsp}, 32'b100);
    check("rst_scratch_zero", dout4, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
